// File: rtl/floatli_pkg.sv
// Shared definitions for the floatli exponent datapath.
//   exp_op_e  : exponent operation select (ADD = a+b+cin, MUL = a+b-bias+cin)
//   EXP_EXT   : extra result bits so sums and biased products never wrap
//   exp_bias(): IEEE-style exponent bias for a given exponent field width
package floatli_pkg;

    typedef enum logic {
        EXP_ADD = 1'b0,
        EXP_MUL = 1'b1
    } exp_op_e;

    // One bit for the carry out of a+b+cin, one bit for the sign after bias removal.
    localparam int EXP_EXT = 2;

    function automatic int exp_bias(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

endpackage

// File: rtl/floatli_exp_adder_lane.sv
// One lane of the exponent adder, purely combinational.
//   a, b   : biased exponents (unsigned, EXP_WIDTH bits)
//   cin    : carry-in
//   op     : EXP_ADD or EXP_MUL (MUL removes one bias)
//   result : signed two's-complement result, EXP_WIDTH+EXP_EXT bits
//   ovf    : result >= 2^EXP_WIDTH-1 (max/inf exponent)
//   uf     : result <= 0 (subnormal/zero range)
module floatli_exp_adder_lane
    import floatli_pkg::*;
#(
    parameter int EXP_WIDTH = 11
) (
    input  logic [EXP_WIDTH-1:0]                 a,
    input  logic [EXP_WIDTH-1:0]                 b,
    input  logic                                 cin,
    input  exp_op_e                              op,
    output logic signed [EXP_WIDTH+EXP_EXT-1:0]  result,
    output logic                                 ovf,
    output logic                                 uf
);

    localparam int RW = EXP_WIDTH + EXP_EXT;
    localparam logic signed [RW-1:0] BIAS    = RW'(exp_bias(EXP_WIDTH));
    localparam logic signed [RW-1:0] MAX_EXP = RW'((1 << EXP_WIDTH) - 1);

    logic signed [RW-1:0] sum;

    always_comb begin
        // Zero-extend first so the carry out of a+b+cin lands in the extension bits.
        sum    = RW'(a) + RW'(b) + RW'(cin);
        result = (op == EXP_MUL) ? (sum - BIAS) : sum;
        ovf    = (result >= MAX_EXP);
        uf     = result[RW-1] | (result == '0);
    end

endmodule

// File: rtl/floatli_exp_adder_pipe.sv
// Multi-lane pipelined exponent adder with valid/ready handshake and flush.
//   clk_i, rst_ni           : clock, async active-low reset
//   exp_a_i, exp_b_i        : per-lane biased exponents
//   carry_i                 : per-lane carry-in
//   op_i                    : 0 = ADD, 1 = MUL (bias removed)
//   tag_i / tag_o           : opaque tag travelling with the operation
//   in_valid_i / in_ready_o : input handshake
//   flush_i                 : kills every in-flight op (and any input this cycle)
//   result_o, ovf_o, uf_o   : per-lane signed result and range flags
//   out_valid_o/out_ready_i : output handshake
//   busy_o                  : some stage holds a valid op
module floatli_exp_adder_pipe
    import floatli_pkg::*;
#(
    parameter int EXP_WIDTH     = 11,
    parameter int NUM_LANES     = 1,
    parameter int NUM_PIPE_REGS = 1,
    parameter int TAG_WIDTH     = 1
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NUM_LANES-1:0][EXP_WIDTH-1:0]           exp_a_i,
    input  logic [NUM_LANES-1:0][EXP_WIDTH-1:0]           exp_b_i,
    input  logic [NUM_LANES-1:0]                          carry_i,
    input  logic                                          op_i,
    input  logic [TAG_WIDTH-1:0]                          tag_i,
    input  logic                                          in_valid_i,
    output logic                                          in_ready_o,
    input  logic                                          flush_i,
    output logic [NUM_LANES-1:0][EXP_WIDTH+EXP_EXT-1:0]   result_o,
    output logic [NUM_LANES-1:0]                          ovf_o,
    output logic [NUM_LANES-1:0]                          uf_o,
    output logic [TAG_WIDTH-1:0]                          tag_o,
    output logic                                          out_valid_o,
    input  logic                                          out_ready_i,
    output logic                                          busy_o
);

    localparam int RW = EXP_WIDTH + EXP_EXT;

    typedef struct packed {
        logic [NUM_LANES-1:0][RW-1:0] result;
        logic [NUM_LANES-1:0]         ovf;
        logic [NUM_LANES-1:0]         uf;
        logic [TAG_WIDTH-1:0]         tag;
    } stage_t;

    logic [NUM_LANES-1:0][RW-1:0] lane_res;
    logic [NUM_LANES-1:0]         lane_ovf;
    logic [NUM_LANES-1:0]         lane_uf;
    stage_t                       comb_d;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        floatli_exp_adder_lane #(
            .EXP_WIDTH (EXP_WIDTH)
        ) u_lane (
            .a      (exp_a_i[l]),
            .b      (exp_b_i[l]),
            .cin    (carry_i[l]),
            .op     (exp_op_e'(op_i)),
            .result (lane_res[l]),
            .ovf    (lane_ovf[l]),
            .uf     (lane_uf[l])
        );
    end

    always_comb begin
        comb_d.result = lane_res;
        comb_d.ovf    = lane_ovf;
        comb_d.uf     = lane_uf;
        comb_d.tag    = tag_i;
    end

    if (NUM_PIPE_REGS == 0) begin : g_comb
        assign result_o    = comb_d.result;
        assign ovf_o       = comb_d.ovf;
        assign uf_o        = comb_d.uf;
        assign tag_o       = comb_d.tag;
        assign out_valid_o = in_valid_i;
        assign in_ready_o  = out_ready_i;
        assign busy_o      = 1'b0;
    end else begin : g_pipe
        localparam int N = NUM_PIPE_REGS;
        localparam logic [N-1:0] ALL = '1;

        logic [N-1:0] vld_pipe;
        logic [N-1:0] vld_in;
        logic [N-1:0] rdy;
        stage_t       data_q  [N];
        stage_t       data_in [N];

        // Stage k can accept when any stage from k onward is empty or the
        // output drains; computed flat to avoid a combinational chain on rdy.
        always_comb begin
            for (int k = 0; k < N; k++) begin
                rdy[k] = out_ready_i | ~&(vld_pipe | ~(ALL << k));
            end
        end

        always_comb begin
            vld_in[0]  = in_valid_i;
            data_in[0] = comb_d;
            for (int k = 1; k < N; k++) begin
                vld_in[k]  = vld_pipe[k-1];
                data_in[k] = data_q[k-1];
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                vld_pipe <= '0;
                for (int k = 0; k < N; k++) data_q[k] <= '0;
            end else begin
                for (int k = 0; k < N; k++) begin
                    if (flush_i) begin
                        vld_pipe[k] <= 1'b0;
                    end else if (rdy[k]) begin
                        vld_pipe[k] <= vld_in[k];
                        if (vld_in[k]) data_q[k] <= data_in[k];
                    end
                end
            end
        end

        assign in_ready_o  = rdy[0];
        assign out_valid_o = vld_pipe[N-1];
        assign busy_o      = |vld_pipe;
        assign result_o    = data_q[N-1].result;
        assign ovf_o       = data_q[N-1].ovf;
        assign uf_o        = data_q[N-1].uf;
        assign tag_o       = data_q[N-1].tag;
    end

endmodule

// File: tb/tb_floatli_exp_adder_pipe.sv
// Directed bench for floatli_exp_adder_pipe: EXP_WIDTH=8, 2 lanes, 2 stages.
module tb_floatli_exp_adder_pipe;

    localparam int EW = 8;
    localparam int NL = 2;
    localparam int NP = 2;
    localparam int TW = 4;
    localparam int RW = EW + 2;

    logic                       clk;
    logic                       rst_ni;
    logic [NL-1:0][EW-1:0]      exp_a_i;
    logic [NL-1:0][EW-1:0]      exp_b_i;
    logic [NL-1:0]              carry_i;
    logic                       op_i;
    logic [TW-1:0]              tag_i;
    logic                       in_valid_i;
    logic                       in_ready_o;
    logic                       flush_i;
    logic [NL-1:0][RW-1:0]      result_o;
    logic [NL-1:0]              ovf_o;
    logic [NL-1:0]              uf_o;
    logic [TW-1:0]              tag_o;
    logic                       out_valid_o;
    logic                       out_ready_i;
    logic                       busy_o;

    int n_chk = 0;
    int n_bad = 0;

    floatli_exp_adder_pipe #(
        .EXP_WIDTH(EW), .NUM_LANES(NL), .NUM_PIPE_REGS(NP), .TAG_WIDTH(TW)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .exp_a_i(exp_a_i), .exp_b_i(exp_b_i),
        .carry_i(carry_i), .op_i(op_i), .tag_i(tag_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .flush_i(flush_i), .result_o(result_o),
        .ovf_o(ovf_o), .uf_o(uf_o), .tag_o(tag_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_op(input logic [7:0] a0, b0, a1, b1, input logic [1:0] c,
                          input logic op, input logic [3:0] t);
        exp_a_i[0] = a0; exp_b_i[0] = b0;
        exp_a_i[1] = a1; exp_b_i[1] = b1;
        carry_i    = c;
        op_i       = op;
        tag_i      = t;
    endtask

    // Present one op for exactly one edge (caller ensures in_ready_o is high).
    task automatic launch(input logic [7:0] a0, b0, a1, b1, input logic [1:0] c,
                          input logic op, input logic [3:0] t);
        set_op(a0, b0, a1, b1, c, op, t);
        in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    int   sent;
    int   got;
    logic acc;
    logic was_stall;
    logic [RW-1:0] hold_r;
    logic [TW-1:0] hold_t;

    initial begin
        rst_ni = 1'b0; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b1;
        set_op(0, 0, 0, 0, 2'b00, 1'b0, 4'd0);
        #1;
        chk("rst_vld",  out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_res",  result_o, 0);
        chk("rst_tag",  tag_o, 0);
        @(negedge clk); @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("rst_rdy", in_ready_o, 1);

        // MUL 127+127-127 = 127, latency 2
        launch(127, 127, 3, 4, 2'b00, 1'b1, 4'd5);
        @(negedge clk);
        chk("lat_v0", out_valid_o, 0);
        chk("lat_busy", busy_o, 1);
        @(negedge clk);
        chk("lat_v1", out_valid_o, 1);
        chk("mul_res0", result_o[0], 127);
        chk("mul_ovf0", ovf_o[0], 0);
        chk("mul_uf0",  uf_o[0], 0);
        chk("mul_tag",  tag_o, 5);

        // MUL 254+254 -> 381 ovf; lane1 1+1 -> -125 uf
        launch(254, 254, 1, 1, 2'b00, 1'b1, 4'd6);
        @(negedge clk); @(negedge clk);
        chk("ovf_res0", result_o[0], 381);
        chk("ovf_ovf0", ovf_o[0], 1);
        chk("ovf_uf0",  uf_o[0], 0);
        chk("uf_res1",  result_o[1], 10'h383);
        chk("uf_uf1",   uf_o[1], 1);
        chk("uf_ovf1",  ovf_o[1], 0);

        // ADD 255+255+1 = 511 no wrap; lane1 0+0 = 0 -> uf
        launch(255, 255, 0, 0, 2'b01, 1'b0, 4'd7);
        @(negedge clk); @(negedge clk);
        chk("add_res0", result_o[0], 511);
        chk("add_ovf0", ovf_o[0], 1);
        chk("add_uf0",  uf_o[0], 0);
        chk("add_res1", result_o[1], 0);
        chk("add_uf1",  uf_o[1], 1);

        // Backpressure: 4 ops, out_ready low for the first 3 cycles
        sent = 0; got = 0; acc = 1'b0; was_stall = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (acc) sent++;
            out_ready_i = (c >= 3);
            in_valid_i  = (sent < 4);
            set_op(8'(100 + sent), 20, 8'(sent), 8'(sent), 2'b10, 1'b0, 4'(sent));
            @(negedge clk);
            acc = in_valid_i & in_ready_o;
            if (c == 2) chk("bp_full_rdy", in_ready_o, 0);
            if (was_stall) begin
                chk("bp_hold_res", result_o[0], hold_r);
                chk("bp_hold_tag", tag_o, hold_t);
            end
            was_stall = out_valid_o & ~out_ready_i;
            hold_r = result_o[0];
            hold_t = tag_o;
            if (was_stall) chk("bp_stall_tag", tag_o, got);
            if (out_valid_o & out_ready_i) begin
                chk("bp_tag",  tag_o, got);
                chk("bp_res0", result_o[0], 120 + got);
                chk("bp_res1", result_o[1], 2 * got + 1);
                got++;
            end
        end
        in_valid_i = 1'b0;
        chk("bp_cnt", got, 4);

        // Flush with two ops in flight plus a new input
        out_ready_i = 1'b1;
        launch(10, 10, 0, 0, 2'b00, 1'b0, 4'd8);
        launch(11, 11, 0, 0, 2'b00, 1'b0, 4'd9);
        set_op(12, 12, 0, 0, 2'b00, 1'b0, 4'd10);
        in_valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        chk("fl_vld0",  out_valid_o, 0);
        chk("fl_busy",  busy_o, 0);
        @(negedge clk);
        chk("fl_vld1",  out_valid_o, 0);
        launch(20, 30, 5, 5, 2'b00, 1'b0, 4'd11);
        @(negedge clk);
        chk("fl_lat0",  out_valid_o, 0);
        @(negedge clk);
        chk("fl_lat1",  out_valid_o, 1);
        chk("fl_tag",   tag_o, 11);
        chk("fl_res0",  result_o[0], 50);
        chk("fl_res1",  result_o[1], 10);

        // Async reset mid-stream
        launch(40, 40, 0, 0, 2'b00, 1'b1, 4'd12);
        @(negedge clk); @(negedge clk);
        out_ready_i = 1'b0;
        chk("ar_pre_vld", out_valid_o, 1);
        chk("ar_pre_res", result_o[0], 10'h3D1);
        chk("ar_pre_uf",  uf_o[0], 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("ar_vld",  out_valid_o, 0);
        chk("ar_busy", busy_o, 0);
        chk("ar_res",  result_o, 0);
        chk("ar_tag",  tag_o, 0);
        #4 rst_ni = 1'b1;
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("ar_rdy",     in_ready_o, 1);
        chk("ar_vld_rel", out_valid_o, 0);
        launch(1, 2, 3, 4, 2'b11, 1'b0, 4'd13);
        @(negedge clk); @(negedge clk);
        chk("ar_post_vld",  out_valid_o, 1);
        chk("ar_post_res0", result_o[0], 4);
        chk("ar_post_res1", result_o[1], 8);
        chk("ar_post_tag",  tag_o, 13);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
